// File: rtl/jtkicker_arb_pkg.sv
// Shared types and grant helpers for the kicker ROM arbiter.
// Slot ids double as round-robin pointer values.
package jtkicker_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] SLOT_MAIN = 2'd0;
  localparam logic [1:0] SLOT_SND  = 2'd1;
  localparam logic [1:0] SLOT_PCM  = 2'd2;

  function automatic logic [1:0] next_slot(input logic [1:0] k);
    return (k == SLOT_PCM) ? SLOT_MAIN : k + 2'd1;
  endfunction

  // First missing slot, scanning from ptr and wrapping main->snd->pcm.
  function automatic logic [1:0] next_grant(input logic [2:0] miss, input logic [1:0] ptr);
    logic [1:0] g;
    logic [1:0] c;
    logic       found;
    g     = ptr;
    c     = ptr;
    found = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!found && miss[c]) begin
        g     = c;
        found = 1'b1;
      end
      c = next_slot(c);
    end
    return g;
  endfunction

  // PCM first: its fetches are paced by the sample rate.
  function automatic logic [1:0] fixed_grant(input logic [2:0] miss);
    if (miss[SLOT_PCM])  return SLOT_PCM;
    if (miss[SLOT_MAIN]) return SLOT_MAIN;
    return SLOT_SND;
  endfunction

endpackage

// File: rtl/jtkicker_arb_slot.sv
// One-word hit cache for a single ROM requester.
// Latency: hit is combinational from registered tag/word; fill lands next clk.
// No backpressure: the arbiter fills at most one slot per cycle.
module jtkicker_arb_slot
  import jtkicker_arb_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs_i,
  input  logic [AW-1:0] addr_i,
  input  logic          fill_i,
  input  logic [AW-2:0] fill_tag_i,
  input  logic [15:0]   fill_word_i,
  output logic          ok_o,
  output logic [7:0]    data_o
);

  logic          valid_q;
  logic [AW-2:0] tag_q;
  logic [15:0]   word_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      word_q  <= '0;
    end else if (fill_i) begin
      valid_q <= 1'b1;
      tag_q   <= fill_tag_i;
      word_q  <= fill_word_i;
    end
  end

  assign ok_o   = cs_i & valid_q & (addr_i[AW-1:1] == tag_q);
  assign data_o = addr_i[0] ? word_q[15:8] : word_q[7:0];

endmodule

// File: rtl/jtkicker_rom_arb.sv
// Shares one SDRAM read port between main CPU, sound CPU and PCM ROM readers.
// Latency: hit 0 clk; miss 1 clk to sdram_req + SDRAM ack/dst time + 1 clk to ok.
// Backpressure: one request in flight, req held until sdram_ack. JTKICKER_ROMARB_FIXPRIO_EN selects fixed priority.
module jtkicker_rom_arb
  import jtkicker_arb_pkg::*;
#(
  parameter int          MAIN_AW  = 16,
  parameter int          SND_AW   = 13,
  parameter int          PCM_AW   = 16,
  parameter logic [21:0] MAIN_OFS = 22'h0,
  parameter logic [21:0] SND_OFS  = 22'h0,
  parameter logic [21:0] PCM_OFS  = 22'h0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               main_cs,
  input  logic [MAIN_AW-1:0] main_addr,
  output logic [7:0]         main_data,
  output logic               main_ok,
  input  logic               snd_cs,
  input  logic [SND_AW-1:0]  snd_addr,
  output logic [7:0]         snd_data,
  output logic               snd_ok,
  input  logic               pcm_cs,
  input  logic [PCM_AW-1:0]  pcm_addr,
  output logic [7:0]         pcm_data,
  output logic               pcm_ok,
  output logic               sdram_req,
  output logic [21:0]        sdram_addr,
  input  logic               sdram_ack,
  input  logic               sdram_dst,
  input  logic [15:0]        sdram_dout,
  output logic               busy
);

  localparam int AWM = (MAIN_AW > SND_AW) ? ((MAIN_AW > PCM_AW) ? MAIN_AW : PCM_AW)
                                          : ((SND_AW > PCM_AW) ? SND_AW : PCM_AW);
  localparam int TW  = AWM - 1;

  state_t        state_q, state_d;
  logic [1:0]    slot_q, slot_d;
  logic [21:0]   addr_q, addr_d;
  logic [TW-1:0] tag_q, tag_d;
  logic          fill;
  logic [1:0]    grant;
  logic [2:0]    miss;
  logic [21:0]   wa [3];
  logic [TW-1:0] tg [3];

  assign miss  = {pcm_cs & ~pcm_ok, snd_cs & ~snd_ok, main_cs & ~main_ok};
  assign wa[0] = MAIN_OFS + 22'(main_addr[MAIN_AW-1:1]);
  assign wa[1] = SND_OFS  + 22'(snd_addr[SND_AW-1:1]);
  assign wa[2] = PCM_OFS  + 22'(pcm_addr[PCM_AW-1:1]);
  assign tg[0] = TW'(main_addr[MAIN_AW-1:1]);
  assign tg[1] = TW'(snd_addr[SND_AW-1:1]);
  assign tg[2] = TW'(pcm_addr[PCM_AW-1:1]);

`ifdef JTKICKER_ROMARB_FIXPRIO_EN
  assign grant = fixed_grant(miss);
`else
  logic [1:0] ptr_q, ptr_d;

  assign grant = next_grant(miss, ptr_q);
  assign ptr_d = (state_q == ST_IDLE && |miss) ? next_slot(grant) : ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= SLOT_MAIN;
    else        ptr_q <= ptr_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    addr_d  = addr_q;
    tag_d   = tag_q;
    fill    = 1'b0;
    case (state_q)
      ST_IDLE: if (|miss) begin
        state_d = ST_REQ;
        slot_d  = grant;
        addr_d  = wa[grant];
        tag_d   = tg[grant];
      end
      // ack and dst together collapse straight back to IDLE
      ST_REQ: if (sdram_ack) begin
        if (sdram_dst) begin
          fill    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: if (sdram_dst) begin
        fill    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      slot_q  <= SLOT_MAIN;
      addr_q  <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      addr_q  <= addr_d;
      tag_q   <= tag_d;
    end
  end

  assign sdram_req  = (state_q == ST_REQ);
  assign sdram_addr = addr_q;
  assign busy       = (state_q != ST_IDLE);

  jtkicker_arb_slot #(.AW(MAIN_AW)) u_main (
    .clk(clk), .rst_n(rst_n), .cs_i(main_cs), .addr_i(main_addr),
    .fill_i(fill && slot_q == SLOT_MAIN), .fill_tag_i(tag_q[MAIN_AW-2:0]),
    .fill_word_i(sdram_dout), .ok_o(main_ok), .data_o(main_data)
  );

  jtkicker_arb_slot #(.AW(SND_AW)) u_snd (
    .clk(clk), .rst_n(rst_n), .cs_i(snd_cs), .addr_i(snd_addr),
    .fill_i(fill && slot_q == SLOT_SND), .fill_tag_i(tag_q[SND_AW-2:0]),
    .fill_word_i(sdram_dout), .ok_o(snd_ok), .data_o(snd_data)
  );

  jtkicker_arb_slot #(.AW(PCM_AW)) u_pcm (
    .clk(clk), .rst_n(rst_n), .cs_i(pcm_cs), .addr_i(pcm_addr),
    .fill_i(fill && slot_q == SLOT_PCM), .fill_tag_i(tag_q[PCM_AW-2:0]),
    .fill_word_i(sdram_dout), .ok_o(pcm_ok), .data_o(pcm_data)
  );

endmodule

// File: tb/tb_jtkicker_rom_arb.sv
// Bench for jtkicker_rom_arb: per-requester cache model plus directed SDRAM responder.
module tb_jtkicker_rom_arb;

  localparam logic [21:0] MAIN_OFS = 22'h000000;
  localparam logic [21:0] SND_OFS  = 22'h010000;
  localparam logic [21:0] PCM_OFS  = 22'h3FFFF0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        main_cs, snd_cs, pcm_cs;
  logic [15:0] main_addr;
  logic [12:0] snd_addr;
  logic [15:0] pcm_addr;
  logic [7:0]  main_data, snd_data, pcm_data;
  logic        main_ok, snd_ok, pcm_ok;
  logic        sdram_req, sdram_ack, sdram_dst, busy;
  logic [21:0] sdram_addr;
  logic [15:0] sdram_dout;

  always #5 clk = ~clk;

  // requester drive and cache model
  bit          r_cs   [3];
  logic [15:0] r_addr [3];
  bit          m_valid[3];
  logic [14:0] m_tag  [3];
  logic [15:0] m_word [3];
  logic [21:0] last_waddr;

  int nvec = 0;
  int nerr = 0;

  assign main_cs   = r_cs[0];
  assign snd_cs    = r_cs[1];
  assign pcm_cs    = r_cs[2];
  assign main_addr = r_addr[0];
  assign snd_addr  = r_addr[1][12:0];
  assign pcm_addr  = r_addr[2];

  jtkicker_rom_arb #(
    .MAIN_AW(16), .SND_AW(13), .PCM_AW(16),
    .MAIN_OFS(MAIN_OFS), .SND_OFS(SND_OFS), .PCM_OFS(PCM_OFS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .main_cs(main_cs), .main_addr(main_addr), .main_data(main_data), .main_ok(main_ok),
    .snd_cs(snd_cs), .snd_addr(snd_addr), .snd_data(snd_data), .snd_ok(snd_ok),
    .pcm_cs(pcm_cs), .pcm_addr(pcm_addr), .pcm_data(pcm_data), .pcm_ok(pcm_ok),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
    .sdram_dst(sdram_dst), .sdram_dout(sdram_dout), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [21:0] ofs(input int k);
    case (k)
      0:       return MAIN_OFS;
      1:       return SND_OFS;
      default: return PCM_OFS;
    endcase
  endfunction

  function automatic logic [21:0] exp_waddr(input int k, input logic [15:0] a);
    logic [22:0] s;
    s = {1'b0, ofs(k)} + {8'd0, a[15:1]};
    return s[21:0];
  endfunction

  function automatic logic m_ok(input int k);
    return r_cs[k] && m_valid[k] && (m_tag[k] == r_addr[k][15:1]);
  endfunction

  function automatic logic [7:0] m_data(input int k);
    return r_addr[k][0] ? m_word[k][15:8] : m_word[k][7:0];
  endfunction

  function automatic logic dut_ok(input int k);
    case (k)
      0:       return main_ok;
      1:       return snd_ok;
      default: return pcm_ok;
    endcase
  endfunction

  function automatic logic [7:0] dut_data(input int k);
    case (k)
      0:       return main_data;
      1:       return snd_data;
      default: return pcm_data;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_valid[k] = 1'b0;
      m_tag[k]   = '0;
      m_word[k]  = '0;
    end
  endtask

  task automatic set_req(input int k, input bit cs, input logic [15:0] a);
    r_cs[k]   = cs;
    r_addr[k] = a;
  endtask

  // every cycle: ok/data of each requester against the cache model
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ok[%0d]", k), 32'(dut_ok(k)), 32'(m_ok(k)));
      chk($sformatf("data[%0d]", k), 32'(dut_data(k)), 32'(m_data(k)));
    end
  end

  task automatic wait_req(output bit got);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = sdram_req;
    end
    chk("req_seen", 32'(got), 32'd1);
  endtask

  // Accept one request for requester k, return word w; optionally drop cs during WAIT.
  task automatic serve(input int k, input logic [15:0] a, input logic [15:0] w,
                       input bit same, input bit drop);
    bit got;
    wait_req(got);
    if (!got) return;
    last_waddr = sdram_addr;
    chk($sformatf("sdram_addr[%0d]", k), 32'(sdram_addr), 32'(exp_waddr(k, a)));
    @(posedge clk); #1;
    sdram_ack = 1'b1;
    if (same) begin
      sdram_dst  = 1'b1;
      sdram_dout = w;
    end
    @(posedge clk); #1;
    sdram_ack = 1'b0;
    sdram_dst = 1'b0;
    if (!same) begin
      if (drop) r_cs[k] = 1'b0;
      @(negedge clk);
      chk("req_after_ack", 32'(sdram_req), 32'd0);
      chk("busy_wait", 32'(busy), 32'd1);
      @(posedge clk); #1;
      sdram_dst  = 1'b1;
      sdram_dout = w;
      @(posedge clk); #1;
      sdram_dst = 1'b0;
    end
    m_valid[k] = 1'b1;
    m_tag[k]   = a[15:1];
    m_word[k]  = w;
  endtask

  task automatic no_req(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("no_req", 32'(sdram_req), 32'd0);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) set_req(k, 1'b0, 16'h0000);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[3];
    logic [15:0] ra[3];
    logic [15:0] rw[3];
    bit got;

    rst_n      = 1'b0;
    sdram_ack  = 1'b0;
    sdram_dst  = 1'b0;
    sdram_dout = 16'h0000;
    last_waddr = '0;
    for (int k = 0; k < 3; k++) set_req(k, 1'b0, 16'h0000);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("rst_req", 32'(sdram_req), 32'd0);
    chk("rst_addr", 32'(sdram_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // first miss and its literal results
    @(posedge clk); #1 set_req(0, 1'b1, 16'h1235);
    serve(0, 16'h1235, 16'hABCD, 1'b0, 1'b0);
    chk("lit_main_waddr", 32'(last_waddr), 32'h0000091A);
    @(negedge clk);
    chk("lit_main_data", 32'(main_data), 32'h000000AB);
    chk("lit_main_ok", 32'(main_ok), 32'd1);

    // hit on the other byte of the same word
    @(posedge clk); #1 set_req(0, 1'b1, 16'h1234);
    @(negedge clk);
    chk("lit_hit_ok", 32'(main_ok), 32'd1);
    chk("lit_hit_data", 32'(main_data), 32'h000000CD);
    no_req(3);

    // simultaneous misses
    do_reset();
    ra[0] = 16'h2000; ra[1] = 16'h0100; ra[2] = 16'h0040;
    rw[0] = 16'hA1B2; rw[1] = 16'hC3D4; rw[2] = 16'hE5F6;
`ifdef JTKICKER_ROMARB_FIXPRIO_EN
    order[0] = 2; order[1] = 0; order[2] = 1;
`else
    order[0] = 0; order[1] = 1; order[2] = 2;
`endif
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) set_req(k, 1'b1, ra[k]);
    for (int i = 0; i < 3; i++) begin
      serve(order[i], ra[order[i]], rw[order[i]], 1'b0, 1'b0);
      if (order[i] == 2) chk("lit_pcm_wrap", 32'(last_waddr), 32'h00000010);
      if (order[i] == 1) chk("lit_snd_waddr", 32'(last_waddr), 32'h00010080);
    end
    @(negedge clk);
    chk("lit_pcm_data", 32'(pcm_data), 32'h000000F6);
    chk("rr_busy_idle", 32'(busy), 32'd0);

    // snd cs dropped while waiting for data
    @(posedge clk); #1 set_req(1, 1'b1, 16'h0201);
    serve(1, 16'h0201, 16'h5566, 1'b0, 1'b1);
    @(negedge clk);
    chk("drop_busy", 32'(busy), 32'd0);
    chk("drop_snd_ok", 32'(snd_ok), 32'd0);
    @(posedge clk); #1 set_req(1, 1'b1, 16'h0201);
    @(negedge clk);
    chk("lit_reraise_ok", 32'(snd_ok), 32'd1);
    chk("lit_reraise_data", 32'(snd_data), 32'h00000055);
    no_req(3);

    // ack and dst on the same cycle
    @(posedge clk); #1 set_req(0, 1'b1, 16'h3001);
    serve(0, 16'h3001, 16'h1122, 1'b1, 1'b0);
    @(negedge clk);
    chk("same_busy", 32'(busy), 32'd0);
    chk("lit_same_data", 32'(main_data), 32'h00000011);
    no_req(3);

    // reset while waiting for data, then a stray dst
    @(posedge clk); #1 set_req(0, 1'b1, 16'h4000);
    wait_req(got);
    @(posedge clk); #1 sdram_ack = 1'b1;
    @(posedge clk); #1 sdram_ack = 1'b0;
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_req", 32'(sdram_req), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_addr", 32'(sdram_addr), 32'd0);
    chk("arst_main_ok", 32'(main_ok), 32'd0);
    chk("arst_snd_data", 32'(snd_data), 32'd0);
    for (int k = 0; k < 3; k++) set_req(k, 1'b0, r_addr[k]);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    sdram_dst  = 1'b1;
    sdram_dout = 16'hDEAD;
    @(posedge clk); #1 sdram_dst = 1'b0;
    @(negedge clk);
    chk("stray_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 set_req(0, 1'b1, 16'h4000);
    @(negedge clk);
    chk("stray_main_ok", 32'(main_ok), 32'd0);
    serve(0, 16'h4000, 16'h7788, 1'b0, 1'b0);
    @(negedge clk);
    chk("lit_after_stray", 32'(main_data), 32'h00000088);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
